// File: rtl/led_matrix_pkg.sv
// Shared types for the row-scanning LED matrix driver.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  // Index width that stays legal for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Scan sequencer: prescaler, PWM slot counter, row counter and IDLE/BLANK/DRIVE FSM.
// Outputs are combinational from the current state; the caller registers them.
module led_pwm_timebase
  import led_matrix_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int PWM_BITS = 3,
  parameter int PRESCALE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  output logic [idx_w(ROWS)-1:0]   row,
  output logic [PWM_BITS-1:0]      pwm_cnt,
  output logic                     drive,
  output logic                     first,
  output logic                     frame_end
);

  localparam int ROW_W   = idx_w(ROWS);
  localparam int PRESC_W = idx_w(PRESCALE);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);
  localparam logic [ROW_W-1:0]   ROW_MAX   = ROW_W'(ROWS - 1);

  scan_state_t        state, state_nxt;
  logic [PRESC_W-1:0] presc_cnt;
  logic               slot_wrap, row_wrap;

  assign slot_wrap = (state == ST_DRIVE) && (presc_cnt == PRESC_MAX);
  assign row_wrap  = slot_wrap && (&pwm_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ena) state_nxt = ST_BLANK;
      ST_BLANK: state_nxt = ST_DRIVE;
      ST_DRIVE: if (row_wrap) state_nxt = ST_BLANK;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!ena) state_nxt = ST_IDLE;
  end

  always_comb begin
    drive     = (state == ST_DRIVE);
    first     = drive && (row == '0) && (pwm_cnt == '0) && (presc_cnt == '0);
    frame_end = row_wrap && (row == ROW_MAX) && ena;
  end

  // Counters only move while driving; dropping ena parks them at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      row       <= '0;
    end else if (!ena) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      row       <= '0;
    end else if (state == ST_DRIVE) begin
      if (slot_wrap) begin
        presc_cnt <= '0;
        pwm_cnt   <= pwm_cnt + 1'b1;
        if (row_wrap) row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_matrix_scan_pwm.sv
// Row-scanned LED matrix with per-pixel PWM and double-buffered frame store.
// All outputs registered one cycle behind the scan state; swaps only at frame end.
module led_matrix_scan_pwm
  import led_matrix_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int PWM_BITS = 3,
  parameter int PRESCALE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    wr_en,
  input  logic [idx_w(ROWS)-1:0]  wr_row,
  input  logic [idx_w(COLS)-1:0]  wr_col,
  input  logic [PWM_BITS-1:0]     wr_level,
  input  logic                    swap_req,
  output logic [ROWS-1:0]         row_sel,
  output logic [COLS-1:0]         col_on,
  output logic                    frame_start,
  output logic                    swap_done
);

  localparam int ROW_W = idx_w(ROWS);

  logic [PWM_BITS-1:0] bank [2][ROWS][COLS];
  logic                buf_sel, swap_pending, do_swap;
  logic [ROW_W-1:0]    row;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                drive, first, frame_end;
  logic [ROWS-1:0]     row_nxt;
  logic [COLS-1:0]     col_nxt;

  led_pwm_timebase #(
    .ROWS     (ROWS),
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .row       (row),
    .pwm_cnt   (pwm_cnt),
    .drive     (drive),
    .first     (first),
    .frame_end (frame_end)
  );

  // Writes always target the bank that is back before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            bank[b][r][c] <= '0;
    end else if (wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS)) begin
      bank[~buf_sel][wr_row][wr_col] <= wr_level;
    end
  end

  assign do_swap = frame_end && (swap_pending || swap_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_sel      <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) begin
        buf_sel      <= ~buf_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    row_nxt      = '0;
    row_nxt[row] = drive;
    col_nxt      = '0;
    for (int c = 0; c < COLS; c++)
      col_nxt[c] = drive && (bank[buf_sel][row][c] > pwm_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_sel     <= '0;
      col_on      <= '0;
      frame_start <= 1'b0;
    end else begin
      row_sel     <= row_nxt;
      col_on      <= col_nxt;
      frame_start <= first;
    end
  end

endmodule
